// File: rtl/sram_bank_arbiter_if.sv
// sram_bank_arbiter_if: requester-side request/response bundle for sram_bank_arbiter
interface sram_bank_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*NUM_WMASKS-1:0] req_wmask;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: per-bank round-robin front end for single-port SRAM macros; SRAM_BANK_OUTREG_EN adds a response register stage
module sram_bank_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int NUM_WMASKS      = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 11,
  parameter int BANK_ADDR_WIDTH = 9,
  localparam int NUM_BANKS      = 2 ** (ADDR_WIDTH - BANK_ADDR_WIDTH)
) (
  input  logic                                 soc_clk,
  input  logic                                 soc_rst_n,
  sram_bank_arbiter_if.slave                   bus,
  output logic [NUM_BANKS-1:0]                 clk0,
  output logic [NUM_BANKS-1:0]                 csb0,
  output logic [NUM_BANKS-1:0]                 web0,
  output logic [NUM_BANKS*NUM_WMASKS-1:0]      wmask0,
  output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] addr0,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]      din0,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      dout0
);
  localparam int BW = ADDR_WIDTH - BANK_ADDR_WIDTH;
  localparam int RW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][BW-1:0]   req_bank;
  logic [NUM_BANKS-1:0][RW-1:0] rr_ptr, rr_nxt, gnt_idx;
  logic [NUM_BANKS-1:0]         gnt_any;
  logic [NUM_REQ-1:0]           ready;
  logic [NUM_BANKS-1:0]         web_q;
  logic [NUM_BANKS*NUM_WMASKS-1:0]      wmask_q;
  logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] addr_q;
  logic [NUM_BANKS*DATA_WIDTH-1:0]      din_q;
  logic [NUM_REQ-1:0]           rd_pend;
  logic [NUM_REQ-1:0][BW-1:0]   rd_bank;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_c;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_bank
    assign req_bank[r] = bus.req_addr[r*ADDR_WIDTH+BANK_ADDR_WIDTH +: BW];
  end

  assign clk0          = {NUM_BANKS{soc_clk}};
  assign bus.req_ready = ready;

  // Per-bank round-robin: first valid requester for this bank at or after rr_ptr wins
  always_comb begin
    int i;
    i       = 0;
    gnt_any = '0;
    ready   = '0;
    gnt_idx = '0;
    rr_nxt  = rr_ptr;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (int'(rr_ptr[b]) + k) % NUM_REQ;
        if (soc_rst_n && !gnt_any[b] && bus.req_valid[i] && int'(req_bank[i]) == b) begin
          gnt_any[b] = 1'b1;
          gnt_idx[b] = RW'(i);
          rr_nxt[b]  = RW'((i + 1) % NUM_REQ);
          ready[i]   = 1'b1;
        end
      end
  end

  // Winner's payload drives the macro in the grant cycle; idle banks keep their last pin values
  always_comb begin
    csb0   = ~gnt_any;
    web0   = web_q;
    wmask0 = wmask_q;
    addr0  = addr_q;
    din0   = din_q;
    for (int b = 0; b < NUM_BANKS; b++)
      if (gnt_any[b]) begin
        web0[b] = ~bus.req_we[gnt_idx[b]];
        wmask0[b*NUM_WMASKS +: NUM_WMASKS]     = bus.req_wmask[int'(gnt_idx[b])*NUM_WMASKS +: NUM_WMASKS];
        addr0[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = bus.req_addr[int'(gnt_idx[b])*ADDR_WIDTH +: BANK_ADDR_WIDTH];
        din0[b*DATA_WIDTH +: DATA_WIDTH]       = bus.req_wdata[int'(gnt_idx[b])*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // Round-robin pointers, macro pin hold registers and the per-requester read tracking
  always_ff @(posedge soc_clk or negedge soc_rst_n)
    if (!soc_rst_n) begin
      rr_ptr  <= '0;
      web_q   <= '1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_pend <= '0;
      rd_bank <= '0;
    end else begin
      rr_ptr  <= rr_nxt;
      web_q   <= web0;
      wmask_q <= wmask0;
      addr_q  <= addr0;
      din_q   <= din0;
      rd_pend <= ready & ~bus.req_we;
      for (int r = 0; r < NUM_REQ; r++)
        if (ready[r] && !bus.req_we[r]) rd_bank[r] <= req_bank[r];
    end

  // Steer each pending read's macro output to its requester
  always_comb begin
    rdata_c = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (rd_pend[r]) rdata_c[r*DATA_WIDTH +: DATA_WIDTH] = dout0[int'(rd_bank[r])*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef SRAM_BANK_OUTREG_EN
  logic [NUM_REQ-1:0]            rsp_valid_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_q;

  // Extra response stage to relax timing from the macro output
  always_ff @(posedge soc_clk or negedge soc_rst_n)
    if (!soc_rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_pend;
      rsp_rdata_q <= rdata_c;
    end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`else
  assign bus.rsp_valid = rd_pend;
  assign bus.rsp_rdata = rdata_c;
`endif
endmodule
